// File: rtl/c2sif_arb_pkg.sv
// Shared types and constants for the c2sif round-robin arbiter.
package c2sif_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DN_REQ = 2'd1,
    UP_ACK = 2'd2,
    DN_REL = 2'd3
  } arb_state_t;

  // Return value reported to the requester when the target never answers.
  localparam logic [63:0] C2SIF_RET_TIMEOUT = '1;
  localparam int unsigned C2SIF_FN_WRITE    = 0;

endpackage

// File: rtl/c2sif_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr, wrapping.
module c2sif_rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int unsigned PW = $clog2(N_REQ);

  // Walk the search order backwards so the candidate closest to ptr is written last.
  always_comb begin
    logic [PW-1:0] cand;
    cand  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % N_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/c2sif_arb.sv
// Shares one downstream c2sif target between N_REQ requesters, round-robin, one
// complete four-phase transaction at a time, with a watchdog on the downstream ack.
module c2sif_arb
  import c2sif_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned IDW     = 8,
  parameter int unsigned FNW     = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         up_req,
  input  logic [N_REQ*IDW-1:0]     up_id,
  input  logic [N_REQ*FNW-1:0]     up_fn,
  input  logic [N_REQ*DW-1:0]      up_data,
  output logic [N_REQ-1:0]         up_ack,
  output logic [DW-1:0]            up_ret,
  output logic                     dn_req,
  output logic [IDW-1:0]           dn_id,
  output logic [FNW-1:0]           dn_fn,
  output logic [DW-1:0]            dn_data,
  input  logic                     dn_ack,
  input  logic [DW-1:0]            dn_ret,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant,
  output logic                     timeout_err
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned CW = 16;

  arb_state_t    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] pick_idx;
  logic          pick_valid;
  logic [CW-1:0] wd_cnt;

  c2sif_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (up_req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      wd_cnt      <= '0;
      up_ack      <= '0;
      up_ret      <= '0;
      dn_req      <= 1'b0;
      dn_id       <= '0;
      dn_fn       <= '0;
      dn_data     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant   <= pick_idx;
            dn_id   <= up_id[pick_idx*IDW +: IDW];
            dn_fn   <= up_fn[pick_idx*FNW +: FNW];
            dn_data <= up_data[pick_idx*DW +: DW];
            dn_req  <= 1'b1;
            busy    <= 1'b1;
            wd_cnt  <= '0;
            state   <= DN_REQ;
          end
        end
        DN_REQ: begin
          // A real ack in the last watchdog cycle still wins over the timeout.
          if (dn_ack) begin
            up_ret <= dn_ret;
            up_ack <= N_REQ'(1) << grant;
            state  <= UP_ACK;
          end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
            up_ret      <= DW'(C2SIF_RET_TIMEOUT);
            up_ack      <= N_REQ'(1) << grant;
            timeout_err <= 1'b1;
            dn_req      <= 1'b0;
            state       <= UP_ACK;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        UP_ACK: begin
          if (!up_req[grant]) begin
            up_ack <= '0;
            dn_req <= 1'b0;
            state  <= DN_REL;
          end
        end
        DN_REL: begin
          // Also swallows a late ack that shows up after a timeout.
          if (!dn_ack) begin
            rr_ptr <= (grant == PW'(N_REQ - 1)) ? '0 : grant + PW'(1);
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
